// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter and command sequencer for a shared W-bit JK bank.
// Up to N requesters use a four-phase req/gnt handshake. The granted requester's J/K
// command is latched, applied once in StApply, and acknowledged with a one-cycle done pulse.
// This block is the only writer of the bank state.
// Build option: define JK_BANK_ARB_FIXED_PRIO_EN for fixed priority, where the lowest index
// always wins. The default build is round-robin.
module jk_bank_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] j_i,
  input  logic [N*W-1:0] k_i,
  output logic [N-1:0]   gnt_o,
  output logic [N-1:0]   done_o,
  output logic [W-1:0]   q_o,
  output logic           busy_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StApply, StWaitRel} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic [W-1:0]    q_q, q_d;
  logic [W-1:0]    j_q, j_d;
  logic [W-1:0]    k_q, k_d;
  logic [PtrW-1:0] win_q, win_d;

  logic [PtrW-1:0] base_ptr;
  logic [PtrW-1:0] win_idx;
  logic            found;
  logic            release_w;

  // The granted requester has dropped req while its command is complete.
  assign release_w = (state_q == StWaitRel) && !req_i[win_q];

`ifdef JK_BANK_ARB_FIXED_PRIO_EN
  // The search always starts at requester 0.
  assign base_ptr = '0;
`else
  logic [PtrW-1:0] ptr_q, ptr_d;

  // On release, the pointer moves to one past the released requester.
  always_comb begin
    ptr_d = ptr_q;
    if (release_w) begin
      ptr_d = (32'(win_q) == N - 1) ? '0 : win_q + 1'b1;
    end
  end

  // Round-robin priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign base_ptr = ptr_q;
`endif

  // Find the first pending request, searching upward from base_ptr and wrapping mod N.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      logic [PtrW-1:0] cand;
      cand = PtrW'((32'(base_ptr) + off) % N);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and datapath logic for the grant/apply/release sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    q_d     = q_q;
    j_d     = j_q;
    k_d     = k_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          win_d          = win_idx;
          // Latch the command now; later changes on j_i/k_i are ignored.
          j_d            = j_i[32'(win_idx)*W +: W];
          k_d            = k_i[32'(win_idx)*W +: W];
          state_d        = StApply;
        end
      end
      StApply: begin
        // Standard JK update: hold, clear, set, toggle
        q_d           = (j_q & ~q_q) | (~k_q & q_q);
        done_d[win_q] = 1'b1;
        state_d       = StWaitRel;
      end
      StWaitRel: begin
        if (release_w) begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers. Reset discards any latched command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      q_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
      j_q     <= j_d;
      k_q     <= k_d;
      win_q   <= win_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign q_o    = q_q;
  assign busy_o = (state_q != StIdle);

endmodule
